rx_sync_ctrl: RTL and testbench
===============================

Name: rx_sync_ctrl

Overview:
- Sequences the receive synchronisation chain: short-preamble detector, then long-preamble aligner, then packet decode.
- Gates the enables and resets of both sync stages, and latches the signed coarse phase offset reported with a short-preamble detection.
- Enforces per-stage sample-count timeouts and keeps saturating event counters for debug readout.
- Sits between the power trigger and the sync_short/sync_long instances in the RX top level.

Parameters:
- RESET_CYCLES, 2, clocks that stage resets are held on re-arm.
- LONG_TIMEOUT, 320, samples allowed in WAIT_LONG before abandoning.
- PKT_TIMEOUT, 65535, samples allowed in LOCKED before watchdog abort.
- CNT_WIDTH, 16, width of the debug counters.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  global receive enable
- sample_in_strobe  in  1  one pulse per input sample; all timeouts count these
- power_trigger  in  1  level, high while signal power is above the floor
- short_preamble_detected  in  1  one-cycle pulse from the short sync stage
- phase_offset  in  16  signed phase offset, valid in the cycle the short pulse is high
- long_preamble_detected  in  1  one-cycle pulse from the long sync stage
- pkt_done  in  1  pulse from the decoder, end of packet
- pkt_abort  in  1  pulse from the decoder, header or parity failure
- short_en  out  1  enable for the short sync stage
- short_reset  out  1  active-high synchronous reset to the short sync stage
- long_en  out  1  enable for the long sync stage
- long_reset  out  1  active-high synchronous reset to the long sync stage
- phase_offset_latched  out  16  signed offset captured at short detection
- sync_locked  out  1  one-cycle pulse on entry to LOCKED
- rx_busy  out  1  high in WAIT_LONG or LOCKED
- state  out  3  IDLE=0, REARM=1, SEARCH=2, WAIT_LONG=3, LOCKED=4
- short_det_count  out  CNT_WIDTH  short detections accepted
- long_timeout_count  out  CNT_WIDTH  WAIT_LONG timeouts
- pkt_timeout_count  out  CNT_WIDTH  LOCKED watchdog expiries

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE; all outputs 0; sample counter 0; debug counters 0.
- All outputs are registered. Enables and resets are decoded from the next state, so they reflect a state change in the same clock the state register updates.
- enable low: state is forced to IDLE synchronously; sample counter cleared; counters and phase_offset_latched hold.
- IDLE: short_en=long_en=0. If power_trigger=1 → REARM.
- REARM: short_reset=long_reset=1, both enables 0.
  - Hold for exactly RESET_CYCLES clocks (internal clock counter), then → SEARCH.
  - power_trigger is ignored while in REARM.
- SEARCH: short_en=1, long_en=0.
  - short_preamble_detected=1: capture phase_offset into phase_offset_latched; short_det_count++; clear sample counter; → WAIT_LONG.
  - Otherwise, power_trigger=0 → IDLE.
  - A detection wins over power_trigger=0 in the same cycle.
- WAIT_LONG: short_en=0, long_en=1; sample counter increments on each sample_in_strobe.
  - long_preamble_detected=1: → LOCKED; sync_locked=1 for that one clock; clear sample counter.
  - Otherwise, when the sample counter reaches LONG_TIMEOUT: long_timeout_count++ → REARM.
  - A detection in the same cycle as the timeout wins, and the counter is not incremented.
  - Short-detection pulses are ignored here.
- LOCKED: long_en=1, short_en=0; sample counter increments on each strobe.
  - pkt_done or pkt_abort → REARM if power_trigger=1, else → IDLE.
  - Otherwise, when the counter reaches PKT_TIMEOUT: pkt_timeout_count++ → IDLE.
  - done/abort wins over the timeout.
  - Further long detections are ignored.
- The sample counter is CNT_WIDTH+1 bits, cleared on every state entry, and never wraps within a state.
- Debug counters saturate at all-ones.
- phase_offset_latched changes only on an accepted short detection.
- reset_n asserted mid-packet: immediate return to the reset values above; no pulse of sync_locked is emitted.

Test Plan:
- Arm and lock: reset → power_trigger=1.
  - REARM for 2 clocks with both resets high, then SEARCH.
  - Short pulse with phase_offset=0xFFF7: WAIT_LONG next clock, latched=0xFFF7, short_det_count=1.
  - Long pulse: one sync_locked pulse, state=4, rx_busy=1.
- Long timeout: in WAIT_LONG, feed 320 strobes with no long pulse → REARM, long_timeout_count=1, phase_offset_latched unchanged.
- Same-cycle races:
  - Long pulse on the 320th strobe → LOCKED, long_timeout_count stays 0.
  - Short pulse with power_trigger=0 → WAIT_LONG.
- Packet end: in LOCKED, pkt_done with power_trigger=1 → REARM; with power_trigger=0 → IDLE; pkt_abort behaves identically.
- Watchdog and saturation:
  - PKT_TIMEOUT=10, no done → IDLE after 10 strobes, pkt_timeout_count=1.
  - Force CNT_WIDTH=4 and drive 17 detections → short_det_count=15.
- Async reset and enable: reset_n low mid-LOCKED → all outputs 0 immediately, without waiting for a clock. enable low in SEARCH → IDLE next clock, counters held.

Source files
------------

// File: rtl/rx_sync_ctrl.sv
// rtl/rx_sync_ctrl.sv - receive synchronisation chain sequencer
//
// Sequences short-preamble search, long-preamble alignment and packet decode.
// Ports:
//   clock, reset_n              system clock, asynchronous active-low reset
//   enable                      global receive enable (low forces IDLE)
//   sample_in_strobe            one pulse per input sample, drives all timeouts
//   power_trigger               level, signal power above the floor
//   short_preamble_detected     pulse from short sync, phase_offset valid with it
//   long_preamble_detected      pulse from long sync
//   pkt_done, pkt_abort         decoder end-of-packet / failure pulses
//   short_en/short_reset        short sync stage enable and synchronous reset
//   long_en/long_reset          long sync stage enable and synchronous reset
//   phase_offset_latched        offset captured at an accepted short detection
//   sync_locked                 one-cycle pulse on entry to LOCKED
//   rx_busy                     high in WAIT_LONG or LOCKED
//   state                       IDLE=0 REARM=1 SEARCH=2 WAIT_LONG=3 LOCKED=4
//   *_count                     saturating debug event counters
module rx_sync_ctrl #(
    parameter int RESET_CYCLES = 2,
    parameter int LONG_TIMEOUT = 320,
    parameter int PKT_TIMEOUT  = 65535,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 sample_in_strobe,
    input  logic                 power_trigger,
    input  logic                 short_preamble_detected,
    input  logic [15:0]          phase_offset,
    input  logic                 long_preamble_detected,
    input  logic                 pkt_done,
    input  logic                 pkt_abort,
    output logic                 short_en,
    output logic                 short_reset,
    output logic                 long_en,
    output logic                 long_reset,
    output logic [15:0]          phase_offset_latched,
    output logic                 sync_locked,
    output logic                 rx_busy,
    output logic [2:0]           state,
    output logic [CNT_WIDTH-1:0] short_det_count,
    output logic [CNT_WIDTH-1:0] long_timeout_count,
    output logic [CNT_WIDTH-1:0] pkt_timeout_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_REARM     = 3'd1,
        S_SEARCH    = 3'd2,
        S_WAIT_LONG = 3'd3,
        S_LOCKED    = 3'd4
    } state_t;

    localparam logic [7:0]           REARM_LAST = 8'(RESET_CYCLES - 1);
    localparam logic [CNT_WIDTH:0]   LONG_LIMIT = (CNT_WIDTH + 1)'(LONG_TIMEOUT);
    localparam logic [CNT_WIDTH:0]   PKT_LIMIT  = (CNT_WIDTH + 1)'(PKT_TIMEOUT);

    state_t               cur_state;
    state_t               nxt_state;
    logic [7:0]           rearm_cnt;
    logic [CNT_WIDTH:0]   samp_cnt;
    logic [CNT_WIDTH:0]   samp_inc;
    logic                 accept_short;
    logic                 long_to;
    logic                 pkt_to;
    logic                 lock_entry;

    assign state = cur_state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur_state <= S_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state    = cur_state;
        accept_short = 1'b0;
        long_to      = 1'b0;
        pkt_to       = 1'b0;
        lock_entry   = 1'b0;
        // Count the current strobe before comparing, so the timeout fires in
        // the same clock as the strobe that reaches the limit and a detection
        // arriving with that strobe can still win.
        samp_inc = samp_cnt;
        if (sample_in_strobe && (samp_cnt != '1)) begin
            samp_inc = samp_cnt + 1'b1;
        end
        if (!enable) begin
            nxt_state = S_IDLE;
        end else begin
            case (cur_state)
                S_IDLE: begin
                    if (power_trigger) nxt_state = S_REARM;
                end
                S_REARM: begin
                    if (rearm_cnt == REARM_LAST) nxt_state = S_SEARCH;
                end
                S_SEARCH: begin
                    if (short_preamble_detected) begin
                        accept_short = 1'b1;
                        nxt_state    = S_WAIT_LONG;
                    end else if (!power_trigger) begin
                        nxt_state = S_IDLE;
                    end
                end
                S_WAIT_LONG: begin
                    if (long_preamble_detected) begin
                        lock_entry = 1'b1;
                        nxt_state  = S_LOCKED;
                    end else if (samp_inc >= LONG_LIMIT) begin
                        long_to   = 1'b1;
                        nxt_state = S_REARM;
                    end
                end
                S_LOCKED: begin
                    if (pkt_done || pkt_abort) begin
                        nxt_state = power_trigger ? S_REARM : S_IDLE;
                    end else if (samp_inc >= PKT_LIMIT) begin
                        pkt_to    = 1'b1;
                        nxt_state = S_IDLE;
                    end
                end
                default: nxt_state = S_IDLE;
            endcase
        end
    end

    // Sample and re-arm counters restart on every state entry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            samp_cnt  <= '0;
            rearm_cnt <= '0;
        end else begin
            if (!enable || (nxt_state != cur_state)) begin
                samp_cnt <= '0;
            end else if ((cur_state == S_WAIT_LONG) || (cur_state == S_LOCKED)) begin
                samp_cnt <= samp_inc;
            end
            if (nxt_state != cur_state) begin
                rearm_cnt <= '0;
            end else if (cur_state == S_REARM) begin
                rearm_cnt <= rearm_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            short_det_count      <= '0;
            long_timeout_count   <= '0;
            pkt_timeout_count    <= '0;
            phase_offset_latched <= '0;
        end else begin
            if (accept_short) begin
                phase_offset_latched <= phase_offset;
                if (short_det_count != '1) short_det_count <= short_det_count + 1'b1;
            end
            if (long_to && (long_timeout_count != '1)) begin
                long_timeout_count <= long_timeout_count + 1'b1;
            end
            if (pkt_to && (pkt_timeout_count != '1)) begin
                pkt_timeout_count <= pkt_timeout_count + 1'b1;
            end
        end
    end

    // Stage controls are decoded from the next state so they line up with
    // the state register rather than lagging it by a clock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            short_en    <= 1'b0;
            short_reset <= 1'b0;
            long_en     <= 1'b0;
            long_reset  <= 1'b0;
            rx_busy     <= 1'b0;
            sync_locked <= 1'b0;
        end else begin
            short_en    <= (nxt_state == S_SEARCH);
            short_reset <= (nxt_state == S_REARM);
            long_reset  <= (nxt_state == S_REARM);
            long_en     <= (nxt_state == S_WAIT_LONG) || (nxt_state == S_LOCKED);
            rx_busy     <= (nxt_state == S_WAIT_LONG) || (nxt_state == S_LOCKED);
            sync_locked <= lock_entry;
        end
    end

endmodule

// File: tb/tb_rx_sync_ctrl.sv
// tb/tb_rx_sync_ctrl.sv - self-checking bench for rx_sync_ctrl
module tb_rx_sync_ctrl;

    logic        clock = 1'b0;
    logic        reset_n, enable, strobe, pt, sp, lp, done, abort;
    logic [15:0] po;

    logic        a_sen, a_srst, a_len, a_lrst, a_lock, a_busy;
    logic [15:0] a_lat, a_sdc, a_ltc, a_ptc;
    logic [2:0]  a_state;
    logic        b_sen, b_srst, b_len, b_lrst, b_lock, b_busy;
    logic [15:0] b_lat;
    logic [3:0]  b_sdc, b_ltc, b_ptc;
    logic [2:0]  b_state;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_phase_q[$];
    logic [15:0] exp_phase;
    logic [15:0] exp_short = 16'd0;
    logic [15:0] exp_lto = 16'd0;
    logic [15:0] exp_pto = 16'd0;

    always #5 clock = ~clock;

    rx_sync_ctrl #(.RESET_CYCLES(2), .LONG_TIMEOUT(320), .PKT_TIMEOUT(10), .CNT_WIDTH(16)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .sample_in_strobe(strobe),
        .power_trigger(pt), .short_preamble_detected(sp), .phase_offset(po),
        .long_preamble_detected(lp), .pkt_done(done), .pkt_abort(abort),
        .short_en(a_sen), .short_reset(a_srst), .long_en(a_len), .long_reset(a_lrst),
        .phase_offset_latched(a_lat), .sync_locked(a_lock), .rx_busy(a_busy), .state(a_state),
        .short_det_count(a_sdc), .long_timeout_count(a_ltc), .pkt_timeout_count(a_ptc)
    );

    rx_sync_ctrl #(.RESET_CYCLES(2), .LONG_TIMEOUT(8), .PKT_TIMEOUT(10), .CNT_WIDTH(4)) dut_sat (
        .clock(clock), .reset_n(reset_n), .enable(enable), .sample_in_strobe(strobe),
        .power_trigger(pt), .short_preamble_detected(sp), .phase_offset(po),
        .long_preamble_detected(lp), .pkt_done(done), .pkt_abort(abort),
        .short_en(b_sen), .short_reset(b_srst), .long_en(b_len), .long_reset(b_lrst),
        .phase_offset_latched(b_lat), .sync_locked(b_lock), .rx_busy(b_busy), .state(b_state),
        .short_det_count(b_sdc), .long_timeout_count(b_ltc), .pkt_timeout_count(b_ptc)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // IDLE -> REARM (2 clocks, both resets high) -> SEARCH
    task automatic go_search;
        pt = 1'b1;
        tick();
        checks++; if ({a_state, a_srst, a_lrst, a_sen, a_len} !== {3'd1, 4'b1100}) begin failures++; $display("FAIL rearm1 got=%b exp=%b", {a_state, a_srst, a_lrst, a_sen, a_len}, {3'd1, 4'b1100}); end
        tick();
        checks++; if ({a_state, a_srst, a_lrst} !== {3'd1, 2'b11}) begin failures++; $display("FAIL rearm2 got=%b exp=%b", {a_state, a_srst, a_lrst}, {3'd1, 2'b11}); end
        tick();
        checks++; if ({a_state, a_srst, a_lrst, a_sen, a_len} !== {3'd2, 4'b0010}) begin failures++; $display("FAIL search got=%b exp=%b", {a_state, a_srst, a_lrst, a_sen, a_len}, {3'd2, 4'b0010}); end
    endtask

    task automatic do_short(input logic [15:0] off, input logic ptv);
        po = off; sp = 1'b1; pt = ptv;
        exp_phase_q.push_back(off);
        if (exp_short != 16'hFFFF) exp_short++;
        tick();
        sp = 1'b0; po = 16'h0;
        checks++; if ({a_state, a_sen, a_len, a_busy} !== {3'd3, 3'b011}) begin failures++; $display("FAIL wait_long got=%b exp=%b", {a_state, a_sen, a_len, a_busy}, {3'd3, 3'b011}); end
        exp_phase = (exp_phase_q.size() > 0) ? exp_phase_q.pop_front() : 16'hxxxx;
        checks++; if (a_lat !== exp_phase) begin failures++; $display("FAIL phase_latched got=%h exp=%h", a_lat, exp_phase); end
        checks++; if (a_sdc !== exp_short) begin failures++; $display("FAIL short_count got=%0d exp=%0d", a_sdc, exp_short); end
    endtask

    task automatic do_long;
        lp = 1'b1;
        tick();
        lp = 1'b0;
        checks++; if ({a_state, a_lock, a_busy, a_len, a_sen} !== {3'd4, 4'b1110}) begin failures++; $display("FAIL locked got=%b exp=%b", {a_state, a_lock, a_busy, a_len, a_sen}, {3'd4, 4'b1110}); end
        tick();
        checks++; if ({a_state, a_lock} !== {3'd4, 1'b0}) begin failures++; $display("FAIL lock_pulse got=%b exp=%b", {a_state, a_lock}, {3'd4, 1'b0}); end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; enable = 1'b0; strobe = 1'b0; pt = 1'b0; sp = 1'b0;
        lp = 1'b0; done = 1'b0; abort = 1'b0; po = 16'h0;
        tick(); tick();
        checks++; if ({a_state, a_sen, a_srst, a_len, a_lrst, a_lock, a_busy, a_lat, a_sdc, a_ltc, a_ptc} !== '0) begin failures++; $display("FAIL reset_state got=%h exp=0", {a_state, a_sen, a_srst, a_len, a_lrst, a_lock, a_busy, a_lat, a_sdc, a_ltc, a_ptc}); end
        reset_n = 1'b1; enable = 1'b1;
        tick();
        checks++; if (a_state !== 3'd0) begin failures++; $display("FAIL idle_no_power got=%0d exp=0", a_state); end
    endtask

    task automatic test_arm_lock;
        go_search();
        do_short(16'hFFF7, 1'b1);
        do_long();
    endtask

    task automatic test_long_timeout;
        pt = 1'b0; done = 1'b1;
        tick();
        done = 1'b0;
        checks++; if (a_state !== 3'd0) begin failures++; $display("FAIL done_to_idle got=%0d exp=0", a_state); end
        go_search();
        do_short(16'h1234, 1'b1);
        strobe = 1'b1;
        repeat (319) tick();
        checks++; if (a_state !== 3'd3) begin failures++; $display("FAIL before_long_to got=%0d exp=3", a_state); end
        tick();
        strobe = 1'b0;
        exp_lto++;
        checks++; if ({a_state, a_srst, a_lrst} !== {3'd1, 2'b11}) begin failures++; $display("FAIL long_to_state got=%b exp=%b", {a_state, a_srst, a_lrst}, {3'd1, 2'b11}); end
        checks++; if (a_ltc !== exp_lto) begin failures++; $display("FAIL long_to_count got=%0d exp=%0d", a_ltc, exp_lto); end
        checks++; if (a_lat !== 16'h1234) begin failures++; $display("FAIL long_to_phase got=%h exp=1234", a_lat); end
        tick(); tick();
        checks++; if (a_state !== 3'd2) begin failures++; $display("FAIL rearm_after_to got=%0d exp=2", a_state); end
    endtask

    task automatic test_races;
        do_short(16'h8000, 1'b0);
        strobe = 1'b1;
        repeat (319) tick();
        lp = 1'b1;
        tick();
        lp = 1'b0; strobe = 1'b0;
        checks++; if ({a_state, a_lock} !== {3'd4, 1'b1}) begin failures++; $display("FAIL race_lock got=%b exp=%b", {a_state, a_lock}, {3'd4, 1'b1}); end
        checks++; if (a_ltc !== exp_lto) begin failures++; $display("FAIL race_long_count got=%0d exp=%0d", a_ltc, exp_lto); end
    endtask

    task automatic test_pkt_end;
        for (int i = 0; i < 4; i++) begin
            pt = i[0];
            if (i[1]) abort = 1'b1; else done = 1'b1;
            tick();
            abort = 1'b0; done = 1'b0;
            checks++; if (a_state !== (i[0] ? 3'd1 : 3'd0)) begin failures++; $display("FAIL pkt_end_%0d got=%0d exp=%0d", i, a_state, i[0] ? 1 : 0); end
            if (i[0]) begin
                tick(); tick();
            end else begin
                go_search();
            end
            do_short(16'($urandom), 1'b1);
            do_long();
        end
    endtask

    task automatic test_watchdog;
        strobe = 1'b1;
        repeat (9) tick();
        checks++; if (a_state !== 3'd4) begin failures++; $display("FAIL watchdog_early got=%0d exp=4", a_state); end
        tick();
        strobe = 1'b0;
        exp_pto++;
        checks++; if ({a_state, a_busy, a_len} !== {3'd0, 2'b00}) begin failures++; $display("FAIL watchdog_idle got=%b exp=%b", {a_state, a_busy, a_len}, 5'b0); end
        checks++; if (a_ptc !== exp_pto) begin failures++; $display("FAIL watchdog_count got=%0d exp=%0d", a_ptc, exp_pto); end
    endtask

    task automatic test_enable;
        logic [15:0] held_lat;
        go_search();
        held_lat = a_lat;
        enable = 1'b0;
        tick();
        checks++; if ({a_state, a_sen, a_srst} !== {3'd0, 2'b00}) begin failures++; $display("FAIL enable_low got=%b exp=%b", {a_state, a_sen, a_srst}, 5'b0); end
        checks++; if ({a_sdc, a_ltc, a_ptc} !== {exp_short, exp_lto, exp_pto}) begin failures++; $display("FAIL enable_hold got=%h exp=%h", {a_sdc, a_ltc, a_ptc}, {exp_short, exp_lto, exp_pto}); end
        checks++; if (a_lat !== held_lat) begin failures++; $display("FAIL enable_phase got=%h exp=%h", a_lat, held_lat); end
        enable = 1'b1; pt = 1'b0;
        tick();
    endtask

    task automatic test_async_reset;
        go_search();
        do_short(16'h5A5A, 1'b1);
        do_long();
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if ({a_state, a_sen, a_srst, a_len, a_lrst, a_lock, a_busy, a_lat, a_sdc, a_ltc, a_ptc} !== '0) begin failures++; $display("FAIL async_reset got=%h exp=0", {a_state, a_sen, a_srst, a_len, a_lrst, a_lock, a_busy, a_lat, a_sdc, a_ltc, a_ptc}); end
        pt = 1'b0;
        tick();
        checks++; if (a_lock !== 1'b0) begin failures++; $display("FAIL reset_lock_pulse got=%b exp=0", a_lock); end
        reset_n = 1'b1;
        exp_short = 16'd0; exp_lto = 16'd0; exp_pto = 16'd0;
        exp_phase_q.delete();
        tick();
    endtask

    task automatic test_saturation;
        for (int n = 1; n <= 17; n++) begin
            go_search();
            do_short(16'(n), 1'b1);
            enable = 1'b0;
            tick();
            enable = 1'b1; pt = 1'b0;
            if (n == 14 || n == 17) begin
                checks++; if (b_sdc !== 4'((n > 15) ? 15 : n)) begin failures++; $display("FAIL sat_count_%0d got=%0d exp=%0d", n, b_sdc, (n > 15) ? 15 : n); end
            end
        end
        checks++; if (a_sdc !== 16'd17) begin failures++; $display("FAIL wide_count got=%0d exp=17", a_sdc); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_arm_lock();
        test_long_timeout();
        test_races();
        test_pkt_end();
        test_watchdog();
        test_enable();
        test_async_reset();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
